// File: rtl/sprite_anim_ctrl_if.sv
// Bundle between the player movement logic and sprite_anim_ctrl, and from the
// controller to the sprite ROM. The master drives the animation and lookup
// requests, and the slave (the controller) returns the ROM address and frame.
interface sprite_anim_ctrl_if #(
   parameter int SPRITE_W   = 32,
   parameter int SPRITE_H   = 48,
   parameter int NUM_FRAMES = 9
);
   localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES);
   localparam int XW     = $clog2(SPRITE_W)+1;
   localparam int YW     = $clog2(SPRITE_H)+1;

   logic              anim_tick;
   logic [1:0]        dir;
   logic              moving;
   logic              pix_valid;
   logic [XW-1:0]     pix_x;
   logic [YW-1:0]     pix_y;
   logic [ADDR_W-1:0] rom_addr;
   logic              addr_valid;
   logic [3:0]        frame_idx;
   logic              mirror;

   modport master (output anim_tick, dir, moving, pix_valid, pix_x, pix_y,
                   input  rom_addr, addr_valid, frame_idx, mirror);
   modport slave  (input  anim_tick, dir, moving, pix_valid, pix_x, pix_y,
                   output rom_addr, addr_valid, frame_idx, mirror);
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Walk-animation sequencer and sprite-ROM address generator for one character.
// The optional macro SPRITE_ANIM_PINGPONG_EN selects the 0,1,2,1 ping-pong walk
// cycle. When the macro is undefined, the walk cycle is linear 0..FRAMES_PER_DIR-1.
module sprite_anim_ctrl #(
   parameter int SPRITE_W        = 32,
   parameter int SPRITE_H        = 48,
   parameter int NUM_FRAMES      = 9,
   parameter int FRAMES_PER_DIR  = 3,
   parameter int TICKS_PER_FRAME = 8
) (
   input logic              clk,
   input logic              rst,
   sprite_anim_ctrl_if.slave bus
);
   localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES);
   localparam int AW1    = ADDR_W+1;
   localparam int XW     = $clog2(SPRITE_W)+1;
   localparam int TW     = $clog2(TICKS_PER_FRAME+1);
`ifdef SPRITE_ANIM_PINGPONG_EN
   localparam logic [3:0] PHASE_LAST = 4'd3;
`else
   localparam logic [3:0] PHASE_LAST = 4'(FRAMES_PER_DIR-1);
`endif
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_FRAME-1);

   localparam logic [1:0] D_LEFT = 2'd1, D_UP = 2'd2, D_DOWN = 2'd3;

   typedef enum logic {IDLE, WALK} state_t;

   state_t            state_q, state_d;
   logic [1:0]        dir_q, dir_d;
   logic [3:0]        phase_q, phase_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic [3:0]        frame_q, frame_d;
   logic              mirror_q, mirror_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              addr_valid_q, addr_valid_d;

   logic [XW-1:0]     col;
   logic [AW1-1:0]    addr_full;
   logic              in_bounds;

   // Walk phase to local frame within a direction's group of frames.
   function automatic logic [3:0] seq_of(input logic [3:0] p);
`ifdef SPRITE_ANIM_PINGPONG_EN
      return (p == 4'd3) ? 4'd1 : p;
`else
      return p;
`endif
   endfunction

   // First ROM frame of each direction; LEFT shares the RIGHT frames.
   function automatic logic [3:0] base_of(input logic [1:0] d);
      case (d)
         D_UP:    return 4'(FRAMES_PER_DIR);
         D_DOWN:  return 4'(2*FRAMES_PER_DIR);
         default: return 4'd0;
      endcase
   endfunction

   // The address uses the registered (pre-tick) frame and mirror, so a tick in
   // the same cycle as a lookup does not affect that lookup.
   assign col       = mirror_q ? (XW'(SPRITE_W-1) - bus.pix_x) : bus.pix_x;
   assign in_bounds = (bus.pix_x < XW'(SPRITE_W)) && (bus.pix_y < ($bits(bus.pix_y))'(SPRITE_H));
   assign addr_full = AW1'(frame_q) * AW1'(SPRITE_W*SPRITE_H)
                    + AW1'(bus.pix_y) * AW1'(SPRITE_W) + AW1'(col);

   // State register, including the animation state and the address pipeline stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dir_q        <= D_DOWN;
         phase_q      <= '0;
         tick_q       <= '0;
         frame_q      <= 4'd7;
         mirror_q     <= 1'b0;
         rom_addr_q   <= '0;
         addr_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         phase_q      <= phase_d;
         tick_q       <= tick_d;
         frame_q      <= frame_d;
         mirror_q     <= mirror_d;
         rom_addr_q   <= rom_addr_d;
         addr_valid_q <= addr_valid_d;
      end
   end

   // Next-state logic: the animation advances only on anim_tick, and the lookup
   // is evaluated every cycle.
   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      phase_d      = phase_q;
      tick_d       = tick_q;
      frame_d      = frame_q;
      mirror_d     = mirror_q;
      rom_addr_d   = rom_addr_q;
      addr_valid_d = 1'b0;

      if (bus.anim_tick) begin
         dir_d = bus.dir;
         case (state_q)
            IDLE: begin
               if (bus.moving) begin
                  state_d = WALK;
                  phase_d = '0;
                  tick_d  = '0;
               end
            end
            WALK: begin
               if (!bus.moving) begin
                  state_d = IDLE;
                  phase_d = '0;
                  tick_d  = '0;
               end else if (bus.dir != dir_q) begin
                  phase_d = '0;
                  tick_d  = '0;
               end else if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  phase_d = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
               end else begin
                  tick_d  = tick_q + TW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         frame_d  = base_of(dir_d) + ((state_d == IDLE) ? 4'd1 : seq_of(phase_d));
         mirror_d = (dir_d == D_LEFT);
      end

      if (bus.pix_valid) begin
         addr_valid_d = in_bounds;
         rom_addr_d   = in_bounds ? addr_full[ADDR_W-1:0] : '0;
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.addr_valid = addr_valid_q;
   assign bus.frame_idx  = frame_q;
   assign bus.mirror     = mirror_q;
endmodule
